apb_master_bridge: RTL and testbench

Single APB master that converts a simple valid/ready command interface into APB3 SETUP/ACCESS transfers and decodes the target address onto one of `NUM_SLAVES` one-hot `psel` lines. It sits between the test/system command source and the APB slave memories, which may insert wait states. It handles `pready` wait states, slave errors, decode errors and a bounded-wait timeout. Each completed or aborted transfer returns exactly one response pulse.

---
 rtl/apb_master_bridge_if.sv | 44 ++++
 rtl/apb_master_bridge.sv | 186 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bundle of the command/response handshake and the APB3 bus seen by apb_master_bridge.
// The master modport is the bridge side. The slave modport is the command source plus the APB slaves.
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  // Command channel
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [31:0]                cmd_addr;
  logic [31:0]                cmd_wdata;

  // Response channel
  logic                       rsp_valid;
  logic [31:0]                rsp_rdata;
  logic                       rsp_err;
  logic                       rsp_timeout;

  // APB3 bus
  logic [NUM_SLAVES-1:0]      psel;
  logic                       penable;
  logic                       pwrite;
  logic [31:0]                paddr;
  logic [31:0]                pwdata;
  logic [NUM_SLAVES*32-1:0]   prdata;
  logic [NUM_SLAVES-1:0]      pready;
  logic [NUM_SLAVES-1:0]      pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single APB3 master: turns valid/ready commands into SETUP/ACCESS transfers on one of NUM_SLAVES.
// Handles wait states, slave errors, decode errors and a bounded-wait timeout, with one response per command.
module apb_master_bridge #(
  parameter int NUM_SLAVES     = 4,
  parameter int SLAVE_ADDR_LSB = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_master_bridge_if.master bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [IDX_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              pwrite_q;
  logic [31:0]       paddr_q;
  logic [31:0]       pwdata_q;

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic [31:0]       rsp_rdata_q;

  // Address decode
  // Every address bit above the index field takes part in the decode.
  // An address above the last slave is therefore rejected and does not alias onto a lower slave.
  logic [31:0]       cmd_slot;
  logic [IDX_W-1:0]  cmd_idx;
  logic              cmd_in_range;

  always_comb begin
    cmd_slot     = bus.cmd_addr >> SLAVE_ADDR_LSB;
    cmd_idx      = IDX_W'(cmd_slot);
    cmd_in_range = (cmd_slot < 32'(NUM_SLAVES));
  end

  // Mux the returns of the selected slave
  logic              sel_ready;
  logic              sel_err;
  logic [31:0]       sel_rdata;

  always_comb begin
    sel_ready = bus.pready[sel_idx];
    sel_err   = bus.pslverr[sel_idx];
    sel_rdata = bus.prdata[32*int'(sel_idx) +: 32];
  end

  // Wait-state timeout
  logic [CNT_W:0]    cnt_inc;
  logic              timeout_hit;

  always_comb begin
    cnt_inc     = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);
  end

  // Next-state logic and response values
  logic              rsp_fire;
  logic              rsp_err_d;
  logic              rsp_timeout_d;
  logic [31:0]       rsp_rdata_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    rsp_fire      = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = '0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_next = cmd_in_range ? SETUP : DECERR;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        // Completion on the same edge as the timeout takes priority.
        if (sel_ready) begin
          state_next  = IDLE;
          rsp_fire    = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else if (timeout_hit) begin
          state_next    = IDLE;
          rsp_fire      = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      DECERR: begin
        state_next = IDLE;
        rsp_fire   = 1'b1;
        rsp_err_d  = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command capture, wait counter and response registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sel_idx       <= '0;
      wait_cnt      <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_err_q     <= rsp_err_d;
        rsp_timeout_q <= rsp_timeout_d;
        rsp_rdata_q   <= rsp_rdata_d;
      end

      // A decode error leaves the bus registers untouched, so the bus stays quiet.
      if (state == IDLE && bus.cmd_valid) begin
        sel_idx <= cmd_idx;
        if (cmd_in_range) begin
          pwrite_q <= bus.cmd_write;
          paddr_q  <= bus.cmd_addr;
          pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end

      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !sel_ready && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Bus outputs
  // Select and enable are decoded from the state register.
  // An asynchronous reset therefore drops them at once.
  logic bus_active;

  always_comb begin
    bus_active = (state == SETUP) || (state == ACCESS);
  end

  assign bus.psel        = bus_active ? (NUM_SLAVES'(1) << sel_idx) : '0;
  assign bus.penable     = (state == ACCESS);
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: four modelled APB slaves with programmable wait, error and hang behaviour.
module tb_apb_master_bridge;

  logic pclk = 1'b0;
  logic presetn;

  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.NUM_SLAVES(4)) bus ();

  apb_master_bridge #(
    .NUM_SLAVES     (4),
    .SLAVE_ADDR_LSB (12),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.master)
  );

  // Slave models
  int          wait_cfg [4];
  logic [3:0]  err_cfg;
  logic [3:0]  hang;
  logic [31:0] mem [4][16];
  int          wcnt;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.pready[i]           = !hang[i] && (wcnt >= wait_cfg[i]);
      bus.pslverr[i]          = err_cfg[i];
      bus.prdata[32*i +: 32]  = mem[i][bus.paddr[5:2]];
    end
  end

  always @(posedge pclk) begin
    if (bus.penable && !(|(bus.psel & bus.pready))) wcnt <= wcnt + 1;
    else wcnt <= 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.psel[i] && bus.penable && bus.pready[i] && bus.pwrite && !err_cfg[i])
        mem[i][bus.paddr[5:2]] <= bus.pwdata;
    end
  end

  // Checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-transfer trace: index n is sampled just after the nth edge following the accept edge.
  logic [3:0]  tr_psel   [64];
  logic        tr_pen    [64];
  logic        tr_pwrite [64];
  logic [31:0] tr_paddr  [64];
  logic [31:0] tr_pwdata [64];

  int          g_lat;
  logic        g_ok;
  logic [31:0] g_rdata;
  logic        g_err;
  logic        g_to;

  task automatic snap(input int n);
    tr_psel[n]   = bus.psel;
    tr_pen[n]    = bus.penable;
    tr_pwrite[n] = bus.pwrite;
    tr_paddr[n]  = bus.paddr;
    tr_pwdata[n] = bus.pwdata;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    g_ok = 1'b0; g_lat = 0; g_rdata = '0; g_err = 1'b0; g_to = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tr_psel[i] = '0; tr_pen[i] = 1'b0; tr_pwrite[i] = 1'b0; tr_paddr[i] = '0; tr_pwdata[i] = '0;
    end
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    g_lat = 1;
    snap(0);
    while (g_lat < 40 && !g_ok) begin
      @(posedge pclk); #1;
      g_lat++;
      snap(g_lat - 1);
      if (bus.rsp_valid) begin
        g_ok = 1'b1; g_rdata = bus.rsp_rdata; g_err = bus.rsp_err; g_to = bus.rsp_timeout;
      end
    end
    check("rsp_seen", 32'(g_ok), 32'd1);
    @(posedge pclk); #1;
    check("rsp_one_pulse", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Back-to-back stimulus
  int          sl     [8];
  logic        b_w    [16];
  logic [31:0] b_addr [16];
  logic [31:0] b_data [16];
  logic [31:0] b_exp  [16];

  initial begin
    int pen_cnt;
    int stable;
    int ci;
    int ri;
    int last_e;
    logic will_acc;
    logic seen;

    presetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    err_cfg = '0; hang = '0;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0;
      for (int j = 0; j < 16; j++) mem[i][j] = 32'h5A00_0000 | 32'(i << 8) | 32'(j);
    end

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_psel", 32'(bus.psel), 32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_pwrite", 32'(bus.pwrite), 32'd0);
    check("rst_paddr", bus.paddr, 32'd0);
    check("rst_pwdata", bus.pwdata, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;

    // Zero-wait write then read back on slave 0
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("wr_lat", 32'(g_lat), 32'd3);
    check("wr_err", 32'(g_err), 32'd0);
    check("wr_rdata", g_rdata, 32'd0);
    check("wr_setup_psel", 32'(tr_psel[0]), 32'b0001);
    check("wr_setup_pen", 32'(tr_pen[0]), 32'd0);
    check("wr_access_psel", 32'(tr_psel[1]), 32'b0001);
    check("wr_access_pen", 32'(tr_pen[1]), 32'd1);
    check("wr_pwdata", tr_pwdata[0], 32'hDEAD_BEEF);
    check("wr_paddr", tr_paddr[0], 32'h0000_0010);
    check("wr_idle_psel", 32'(tr_psel[2]), 32'd0);

    issue(1'b0, 32'h0000_0010, 32'h1111_1111);
    check("rd_lat", 32'(g_lat), 32'd3);
    check("rd_rdata", g_rdata, 32'hDEAD_BEEF);
    check("rd_err", 32'(g_err), 32'd0);
    check("rd_pwdata_zero", tr_pwdata[0], 32'd0);

    // Slave 2 read with 3 wait states
    wait_cfg[2] = 3;
    issue(1'b0, 32'h0000_2004, 32'h0);
    wait_cfg[2] = 0;
    pen_cnt = 0;
    stable = 0;
    for (int i = 0; i < 6; i++) if (tr_pen[i]) pen_cnt++;
    for (int i = 0; i < 5; i++)
      if (tr_paddr[i] == 32'h0000_2004 && !tr_pwrite[i] && tr_psel[i] == 4'b0100) stable++;
    check("ws_psel", 32'(tr_psel[0]), 32'b0100);
    check("ws_pen_cycles", 32'(pen_cnt), 32'd4);
    check("ws_lat", 32'(g_lat), 32'd6);
    check("ws_stable", 32'(stable), 32'd5);
    check("ws_rdata", g_rdata, 32'h5A00_0201);

    // Slave error on slave 1
    err_cfg[1] = 1'b1;
    issue(1'b0, 32'h0000_1008, 32'h0);
    err_cfg[1] = 1'b0;
    check("slverr_err", 32'(g_err), 32'd1);
    check("slverr_to", 32'(g_to), 32'd0);
    check("slverr_rdata", g_rdata, 32'd0);
    check("slverr_lat", 32'(g_lat), 32'd3);

    // Decode error
    issue(1'b1, 32'h0000_4000, 32'hCAFE_F00D);
    check("dec_lat", 32'(g_lat), 32'd2);
    check("dec_err", 32'(g_err), 32'd1);
    check("dec_to", 32'(g_to), 32'd0);
    check("dec_rdata", g_rdata, 32'd0);
    check("dec_psel0", 32'(tr_psel[0]), 32'd0);
    check("dec_psel1", 32'(tr_psel[1]), 32'd0);

    // Timeout on slave 3
    hang[3] = 1'b1;
    issue(1'b0, 32'h0000_3000, 32'h0);
    hang[3] = 1'b0;
    pen_cnt = 0;
    for (int i = 0; i < 18; i++) if (tr_pen[i]) pen_cnt++;
    check("to_lat", 32'(g_lat), 32'd18);
    check("to_err", 32'(g_err), 32'd1);
    check("to_flag", 32'(g_to), 32'd1);
    check("to_rdata", g_rdata, 32'd0);
    check("to_pen_cycles", 32'(pen_cnt), 32'd16);
    check("to_idle_psel", 32'(tr_psel[17]), 32'd0);
    check("to_idle_pen", 32'(tr_pen[17]), 32'd0);

    issue(1'b1, 32'h0000_3024, 32'h1234_5678);
    check("post_to_wr_err", 32'(g_err), 32'd0);
    issue(1'b0, 32'h0000_3024, 32'h0);
    check("post_to_rd", g_rdata, 32'h1234_5678);
    check("post_to_rd_to", 32'(g_to), 32'd0);

    // pready rises on the edge the counter would reach 16: completion wins
    wait_cfg[0] = 15;
    issue(1'b0, 32'h0000_0010, 32'h0);
    wait_cfg[0] = 0;
    check("edge_lat", 32'(g_lat), 32'd18);
    check("edge_to", 32'(g_to), 32'd0);
    check("edge_err", 32'(g_err), 32'd0);
    check("edge_rdata", g_rdata, 32'hDEAD_BEEF);

    // Back-to-back: 8 writes then 8 reads with cmd_valid held high
    for (int k = 0; k < 8; k++) begin
      sl[k] = int'($urandom_range(0, 3));
      b_addr[k]     = (32'(sl[k]) << 12) | 32'(k * 4);
      b_data[k]     = 32'hC0DE_0000 + 32'(k * 273);
      b_w[k]        = 1'b1;
      b_exp[k]      = 32'd0;
      b_addr[k + 8] = b_addr[k];
      b_data[k + 8] = 32'd0;
      b_w[k + 8]    = 1'b0;
      b_exp[k + 8]  = b_data[k];
    end
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = b_w[0]; bus.cmd_addr = b_addr[0]; bus.cmd_wdata = b_data[0];
    ci = 0; ri = 0; last_e = -1;
    for (int e = 0; e < 200 && ri < 16; e++) begin
      will_acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge pclk); #1;
      if (bus.rsp_valid) begin
        check("b2b_data", bus.rsp_rdata, b_exp[ri]);
        check("b2b_err", 32'(bus.rsp_err), 32'd0);
        ri++;
        last_e = e;
      end
      if (will_acc) begin
        ci++;
        if (ci < 16) begin
          bus.cmd_write = b_w[ci]; bus.cmd_addr = b_addr[ci]; bus.cmd_wdata = b_data[ci];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      @(negedge pclk);
    end
    bus.cmd_valid = 1'b0;
    check("b2b_count", 32'(ri), 32'd16);
    check("b2b_period", 32'(last_e), 32'd47);

    // Reset during ACCESS
    wait_cfg[3] = 5;
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0000_3030; bus.cmd_wdata = '0;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge pclk);
    @(posedge pclk); #1;
    check("mid_pen_before", 32'(bus.penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("mid_psel_drop", 32'(bus.psel), 32'd0);
    check("mid_pen_drop", 32'(bus.penable), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge pclk); #1;
      seen = seen | bus.rsp_valid;
    end
    @(negedge pclk);
    presetn = 1'b1;
    repeat (8) begin
      @(posedge pclk); #1;
      seen = seen | bus.rsp_valid;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);
    wait_cfg[3] = 0;

    issue(1'b0, 32'h0000_3030, 32'h0);
    check("post_rst_rd", g_rdata, 32'h5A00_030C);
    check("post_rst_lat", 32'(g_lat), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
